rx_frame_assembler: RTL and testbench



---
 rtl/rx_frame_pkg.sv | 19 +
 rtl/rx_idle_timer.sv | 39 +++
 rtl/rx_frame_assembler.sv | 194 +++++++++++++++++++
 tb/tb_rx_frame_assembler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types, constants and the slot-to-bit-offset helper for the
// received-byte frame assembler.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_e;

    localparam int FRAME_BYTES_DEF = 66;
    localparam int FRAME_W         = FRAME_BYTES_DEF * 8;

    // Byte slot 0 sits in the MSBs; returns the LSB position of slot idx.
    function automatic int slot_lsb(input int frame_w, input int idx);
        return frame_w - 8 - 8 * idx;
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles, clears on demand and
// saturates at LIMIT-1, where expired_o stays high until cleared.
module rx_idle_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/rx_frame_assembler.sv
// Collects strobed bytes into one FRAME_BYTES frame (first byte in the MSBs)
// and offers it with valid/ready. Partial frames are dropped on idle timeout
// or frame_abort. Optional build macro FRAME_CHECKSUM_EN: a trailing XOR byte
// follows each frame and a mismatch discards the frame with a chk_err pulse.
module rx_frame_assembler
    import rx_frame_pkg::*;
#(
    parameter int FRAME_BYTES    = FRAME_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     new_byte,
    input  logic                     frame_abort,
    output logic [FRAME_BYTES*8-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [CNT_W-1:0]         byte_count,
    output logic                     overrun,
    output logic                     timeout,
    output logic                     chk_err
);
    localparam int               FW       = FRAME_BYTES * 8;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BYTES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [FW-1:0]    frame_q;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;
    logic             tmr_clear, tmr_en, tmr_expired;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]       xor_q, xor_d;
    logic             chk_err_q, chk_err_d;
`endif

    rx_idle_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmr_clear),
        .enable_i (tmr_en),
        .expired_o(tmr_expired)
    );

    // Next-state, slot write and pulse decisions for the assembler FSM.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        wr_idx    = count_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
        tmr_clear = 1'b1;
        tmr_en    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        xor_d     = xor_q;
        chk_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (new_byte) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    count_d = CNT_W'(1);
                    state_d = FILL;
`ifdef FRAME_CHECKSUM_EN
                    xor_d   = byte_in;
`endif
                end
            end
            FILL: begin
                tmr_clear = 1'b0;
                if (frame_abort) begin
                    // Abort beats a same-cycle byte; that byte is lost.
                    tmr_clear = 1'b1;
                    count_d   = '0;
                    state_d   = IDLE;
                end else if (new_byte) begin
                    tmr_clear = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                    if (count_q == FULL_CNT) begin
                        // Trailer byte: compared, never stored.
                        if (byte_in == xor_q) begin
                            state_d = FULL;
                        end else begin
                            chk_err_d = 1'b1;
                            count_d   = '0;
                            state_d   = IDLE;
                        end
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        xor_d   = xor_q ^ byte_in;
                    end
`else
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == FULL_CNT - CNT_W'(1)) begin
                        state_d = FULL;
                    end
`endif
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    tmr_clear = 1'b1;
                    count_d   = '0;
                    state_d   = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            FULL: begin
                if (frame_ready) begin
                    if (new_byte) begin
                        // Handshake and first byte of the next frame together.
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        count_d = CNT_W'(1);
                        state_d = FILL;
`ifdef FRAME_CHECKSUM_EN
                        xor_d   = byte_in;
`endif
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end else if (new_byte) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Control state, byte counter and one-cycle pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    // Frame storage: only the addressed slot is written, others keep old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    frame_q[slot_lsb(FW, i) +: 8] <= byte_in;
                end
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Running XOR of the frame bytes and the mismatch pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            xor_q     <= xor_d;
            chk_err_q <= chk_err_d;
        end
    end
    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign frame_data  = frame_q;
    assign frame_valid = (state_q == FULL);
    assign byte_count  = count_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Self-checking bench for rx_frame_assembler (TIMEOUT_CYCLES=16).
// Expected frames are built by a byte-level model and queued as bytes are
// driven; each is popped and compared when frame_valid is observed.
module tb_rx_frame_assembler;
    localparam int FB = 66;
    localparam int FW = FB * 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          new_byte = 1'b0;
    logic          frame_abort = 1'b0;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic [6:0]    byte_count;
    logic          overrun, timeout, chk_err;

    int checks = 0;
    int failures = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] model_frame = '0;
    logic [FW-1:0] exp_f;
    logic [7:0]    model_xor = '0;
    int            model_cnt = 0;

    int ovr_cnt = 0, to_cnt = 0, chk_cnt = 0;

    rx_frame_assembler #(
        .FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO), .CNT_W(7)
    ) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .new_byte(new_byte),
        .frame_abort(frame_abort), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .byte_count(byte_count), .overrun(overrun), .timeout(timeout),
        .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (timeout === 1'b1) to_cnt++;
        if (chk_err === 1'b1) chk_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in  = b;
        new_byte = 1'b1;
        @(negedge clk);
        new_byte = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_put(input logic [7:0] b);
        if (model_cnt == 0) model_xor = '0;
        model_frame[FW-1-8*model_cnt -: 8] = b;
        model_xor = model_xor ^ b;
        model_cnt++;
`ifndef FRAME_CHECKSUM_EN
        if (model_cnt == FB) begin
            exp_q.push_back(model_frame);
            model_cnt = 0;
        end
`endif
    endtask

    task automatic data_byte(input logic [7:0] b, input int gap);
        model_put(b);
        send_byte(b);
        idle(gap);
    endtask

    task automatic close_frame();
`ifdef FRAME_CHECKSUM_EN
        if (model_cnt == FB) begin
            send_byte(model_xor);
            exp_q.push_back(model_frame);
            model_cnt = 0;
        end
`endif
    endtask

    task automatic accept();
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if (frame_data !== '0 || frame_valid !== 1'b0 || byte_count !== 7'd0) begin
            failures++;
            $display("FAIL reset_state got valid=%b count=%0d data_nz=%b required valid=0 count=0 data=0",
                     frame_valid, byte_count, |frame_data);
        end
        checks++;
        if ({overrun, timeout, chk_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses got=%b required=000", {overrun, timeout, chk_err});
        end
        rst = 1'b0;
        idle(1);
        $display("reset released");
    endtask

    task automatic test_basic_frame();
        for (int i = 0; i < FB - 1; i++) data_byte(8'(i), 1);
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid got=%b required=0", frame_valid);
        end
        model_put(8'h41);
        send_byte(8'h41);
        close_frame();
        checks++;
        if (frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_valid_latency got=%b required=1", frame_valid);
        end
        checks++;
        if (frame_data[527:520] !== 8'h00 || frame_data[7:0] !== 8'h41) begin
            failures++;
            $display("FAIL basic_ends got=%h/%h required=00/41", frame_data[527:520], frame_data[7:0]);
        end
        checks++;
        if (byte_count !== 7'd66) begin
            failures++;
            $display("FAIL basic_count got=%0d required=66", byte_count);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL basic_frame got=no_expected required=queued_frame");
        end else begin
            exp_f = exp_q.pop_front();
            if (frame_data !== exp_f) begin
                failures++;
                $display("FAIL basic_frame got=%h required=%h", frame_data, exp_f);
            end
        end
        accept();
        checks++;
        if (frame_valid !== 1'b0 || byte_count !== 7'd0) begin
            failures++;
            $display("FAIL basic_handshake got valid=%b count=%0d required valid=0 count=0",
                     frame_valid, byte_count);
        end
        $display("basic frame 00..41 done");
    endtask

    task automatic test_overrun();
        int base;
        for (int i = 0; i < FB; i++) data_byte(8'(8'h80 + i), 0);
        close_frame();
        checks++;
        if (exp_q.size() == 0 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovr_frame got valid=%b queued=%0d required valid=1 queued=1",
                     frame_valid, exp_q.size());
        end else begin
            exp_f = exp_q.pop_front();
            if (frame_data !== exp_f) begin
                failures++;
                $display("FAIL ovr_frame got=%h required=%h", frame_data, exp_f);
            end
        end
        base = ovr_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        idle(1);
        checks++;
        if (ovr_cnt - base !== 2) begin
            failures++;
            $display("FAIL ovr_pulses got=%0d required=2", ovr_cnt - base);
        end
        checks++;
        if (frame_data !== exp_f || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovr_hold got valid=%b data=%h required valid=1 data=%h",
                     frame_valid, frame_data, exp_f);
        end
        model_put(8'hAA);
        @(negedge clk);
        frame_ready = 1'b1;
        byte_in     = 8'hAA;
        new_byte    = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        new_byte    = 1'b0;
        idle(1);
        checks++;
        if (byte_count !== 7'd1 || frame_data[527:520] !== 8'hAA || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_restart got count=%0d slot0=%h valid=%b required count=1 slot0=aa valid=0",
                     byte_count, frame_data[527:520], frame_valid);
        end
        checks++;
        if (ovr_cnt - base !== 2) begin
            failures++;
            $display("FAIL ovr_no_extra got=%0d required=2", ovr_cnt - base);
        end
        for (int i = 1; i < FB; i++) data_byte(8'($urandom_range(0, 255)), 0);
        close_frame();
        checks++;
        if (exp_q.size() == 0 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovr_next_frame got valid=%b queued=%0d required valid=1 queued=1",
                     frame_valid, exp_q.size());
        end else begin
            exp_f = exp_q.pop_front();
            if (frame_data !== exp_f) begin
                failures++;
                $display("FAIL ovr_next_frame got=%h required=%h", frame_data, exp_f);
            end
        end
        accept();
        $display("overrun scenario done");
    endtask

    task automatic test_timeout();
        int first_k, pulses, base;
        logic seen_valid;
        first_k = -1;
        pulses = 0;
        seen_valid = 1'b0;
        base = ovr_cnt;
        for (int i = 0; i < 9; i++) data_byte(8'(8'h30 + i), 1);
        data_byte(8'h39, 0);
        for (int k = 1; k <= TO + 8; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
            if (frame_valid === 1'b1) seen_valid = 1'b1;
        end
        model_cnt = 0;
        checks++;
        if (first_k != TO || pulses != 1) begin
            failures++;
            $display("FAIL timeout_pulse got at=%0d count=%0d required at=%0d count=1", first_k, pulses, TO);
        end
        checks++;
        if (byte_count !== 7'd0 || seen_valid !== 1'b0 || ovr_cnt != base) begin
            failures++;
            $display("FAIL timeout_state got count=%0d valid_seen=%b required count=0 valid_seen=0",
                     byte_count, seen_valid);
        end
        $display("timeout after 10 bytes done");
    endtask

    task automatic test_abort();
        int b_ovr, b_to, b_chk;
        b_ovr = ovr_cnt; b_to = to_cnt; b_chk = chk_cnt;
        for (int i = 0; i < 20; i++) data_byte(8'(8'hC0 + i), 0);
        @(negedge clk);
        frame_abort = 1'b1;
        new_byte    = 1'b1;
        byte_in     = 8'hEE;
        @(negedge clk);
        frame_abort = 1'b0;
        new_byte    = 1'b0;
        model_cnt   = 0;
        checks++;
        if (byte_count !== 7'd0) begin
            failures++;
            $display("FAIL abort_count got=%0d required=0", byte_count);
        end
        idle(1);
        checks++;
        if (ovr_cnt != b_ovr || to_cnt != b_to || chk_cnt != b_chk) begin
            failures++;
            $display("FAIL abort_pulses got=%0d/%0d/%0d required=0/0/0",
                     ovr_cnt - b_ovr, to_cnt - b_to, chk_cnt - b_chk);
        end
        for (int i = 0; i < FB; i++) data_byte(8'($urandom_range(0, 255)), 1);
        close_frame();
        checks++;
        if (exp_q.size() == 0 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_next_frame got valid=%b queued=%0d required valid=1 queued=1",
                     frame_valid, exp_q.size());
        end else begin
            exp_f = exp_q.pop_front();
            if (frame_data !== exp_f) begin
                failures++;
                $display("FAIL abort_next_frame got=%h required=%h", frame_data, exp_f);
            end
        end
        accept();
        $display("abort after 20 bytes done");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 40; i++) data_byte(8'(8'h50 + i), 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (frame_data !== '0 || frame_valid !== 1'b0 || byte_count !== 7'd0 ||
            {overrun, timeout, chk_err} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got count=%0d valid=%b data_nz=%b required all zero",
                     byte_count, frame_valid, |frame_data);
        end
        model_cnt = 0;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < FB; i++) data_byte(8'(8'hFF - i), 0);
        close_frame();
        checks++;
        if (exp_q.size() == 0 || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_next_frame got valid=%b queued=%0d required valid=1 queued=1",
                     frame_valid, exp_q.size());
        end else begin
            exp_f = exp_q.pop_front();
            if (frame_data !== exp_f) begin
                failures++;
                $display("FAIL async_next_frame got=%h required=%h", frame_data, exp_f);
            end
        end
        accept();
        $display("async reset at byte 40 done");
    endtask

    task automatic test_checksum();
`ifdef FRAME_CHECKSUM_EN
        int base;
        for (int i = 0; i < FB; i++) data_byte(8'h01, 0);
        close_frame();
        checks++;
        if (frame_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++;
            $display("FAIL chk_good got valid=%b required=1", frame_valid);
        end else begin
            exp_f = exp_q.pop_front();
            if (frame_data !== exp_f) begin
                failures++;
                $display("FAIL chk_good_data got=%h required=%h", frame_data, exp_f);
            end
        end
        accept();
        base = chk_cnt;
        for (int i = 0; i < FB; i++) data_byte(8'h01, 0);
        send_byte(8'h01);
        model_cnt = 0;
        idle(2);
        checks++;
        if (chk_cnt - base != 1 || frame_valid !== 1'b0 || byte_count !== 7'd0) begin
            failures++;
            $display("FAIL chk_bad got pulses=%0d valid=%b count=%0d required pulses=1 valid=0 count=0",
                     chk_cnt - base, frame_valid, byte_count);
        end
        $display("checksum good/bad trailer done");
`else
        checks++;
        if (chk_cnt != 0) begin
            failures++;
            $display("FAIL chk_tied got=%0d required=0", chk_cnt);
        end
        $display("checksum disabled: chk_err quiet");
`endif
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overrun();
        test_timeout();
        test_abort();
        test_async_reset();
        test_checksum();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
